enable_pulse_gen: RTL and testbench

- Upstream stage for the modulus counter: generates its `enable` input as one-cycle pulses at a programmable rate.
- Run/stop/single-step control lets a bench or top level pace the counter without gating the clock.
- Single clock domain; the output is fully registered and connects directly to the counter's `enable` port.

---
 rtl/enable_gen_pkg.sv | 24 ++
 rtl/enable_pulse_gen_prescaler_core.sv | 40 ++++
 rtl/enable_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_enable_pulse_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enable_gen_pkg.sv
// -----------------------------------------------------------------------------
// enable_gen_pkg
// Shared definitions for the enable pulse generator:
//   state_t      - FSM encoding (IDLE=0, RUN=1, STEP=2)
//   DIV_DEFAULT  - divide ratio loaded at reset
//   DIV_W_MAX    - widest divide register eff_div() can handle
//   eff_div()    - effective ratio rule: ratios 0 and 1 both mean "every cycle"
// -----------------------------------------------------------------------------
package enable_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int DIV_DEFAULT = 4;
  localparam int DIV_W_MAX   = 16;

  function automatic logic [DIV_W_MAX-1:0] eff_div(input logic [DIV_W_MAX-1:0] div);
    return (div < DIV_W_MAX'(2)) ? DIV_W_MAX'(1) : div;
  endfunction

endpackage

// File: rtl/enable_pulse_gen_prescaler_core.sv
// -----------------------------------------------------------------------------
// prescaler_core
// Free-running prescaler counter. pre_cnt counts 0..eff_div-1 while run is
// high and wraps; tick is high (combinationally) in the cycle where the counter
// sits on its last value, i.e. the edge that ends the cycle is a pulse edge.
// Ports:
//   clk, rst  - clock / synchronous active-high reset
//   clear     - synchronous clear of pre_cnt (has priority over run)
//   run       - count enable; tick is forced low while run is low
//   div       - raw divide ratio (0 and 1 both mean divide-by-1)
//   tick      - wrap indicator for the current cycle
// -----------------------------------------------------------------------------
module prescaler_core
  import enable_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0]     pre_cnt;
  logic [DIV_W_MAX-1:0] wrap_at;

  assign wrap_at = eff_div(DIV_W_MAX'(div)) - DIV_W_MAX'(1);
  assign tick    = run && (DIV_W_MAX'(pre_cnt) == wrap_at);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre_cnt <= '0;
    end else if (run) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/enable_pulse_gen.sv
// -----------------------------------------------------------------------------
// enable_pulse_gen
// Produces the downstream counter's enable as registered one-cycle pulses at a
// programmable rate, with run / stop / single-step control.
// Optional feature macro: PRESCALER_BURST_EN (adds burst_len / done and stops
// RUN automatically after burst_len pulses; burst_len == 0 runs until stop).
// Ports:
//   clk, rst    - clock / synchronous active-high reset
//   start       - IDLE -> RUN (stop has priority, start beats step)
//   stop        - RUN -> IDLE; a pulse due on that edge is suppressed
//   step        - in IDLE, emit exactly one enable pulse via STEP
//   div_load    - load div_value into the divide register (IDLE only)
//   div_value   - new divide ratio (0 and 1 mean every cycle)
//   enable      - registered pulse output
//   running     - high while in RUN
//   dbg_state   - current FSM state, for observation
//   burst_len   - pulses per run (PRESCALER_BURST_EN only)
//   done        - one-cycle pulse as running falls at burst end
//                 (PRESCALER_BURST_EN only)
// Handshake: all controls are plain level-sampled inputs; there is no
// valid/ready pair -- a control takes effect at the edge it is sampled high,
// if the current state accepts it, and is otherwise ignored.
// -----------------------------------------------------------------------------
module enable_pulse_gen
  import enable_gen_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = enable_gen_pkg::DIV_DEFAULT,
  parameter int BURST_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               div_load,
  input  logic [DIV_W-1:0]   div_value,
`ifdef PRESCALER_BURST_EN
  input  logic [BURST_W-1:0] burst_len,
  output logic               done,
`endif
  output logic               enable,
  output logic               running,
  output state_t             dbg_state
);

  state_t           state;
  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic             run_ok;

`ifdef PRESCALER_BURST_EN
  logic [BURST_W-1:0] burst_cnt;
  // Set on the edge that issues the final burst pulse; the following edge
  // leaves RUN, so no further pulse may be produced in between.
  logic               burst_last;
`endif

  assign dbg_state = state;

  // The prescaler only advances in a RUN cycle that stays in RUN. Any other
  // cycle clears it, which also gives pre_cnt = 0 on entry to RUN.
  always_comb begin
    run_ok = (state == RUN) && !stop;
`ifdef PRESCALER_BURST_EN
    if (burst_last) run_ok = 1'b0;
`endif
  end

  prescaler_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (!run_ok),
    .run   (run_ok),
    .div   (div_reg),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_reg <= DIV_W'(DIV_DEFAULT);
      enable  <= 1'b0;
      running <= 1'b0;
`ifdef PRESCALER_BURST_EN
      burst_cnt  <= '0;
      burst_last <= 1'b0;
      done       <= 1'b0;
`endif
    end else begin
      enable <= 1'b0;
`ifdef PRESCALER_BURST_EN
      done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (div_load) div_reg <= div_value;
`ifdef PRESCALER_BURST_EN
          burst_cnt  <= '0;
          burst_last <= 1'b0;
`endif
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step && !start) begin
            state  <= STEP;
            enable <= 1'b1;
          end
        end
        RUN: begin
`ifdef PRESCALER_BURST_EN
          if (burst_last) begin
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b1;
            burst_last <= 1'b0;
          end else
`endif
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else begin
            enable <= tick;
`ifdef PRESCALER_BURST_EN
            if (tick) begin
              burst_cnt <= burst_cnt + 1'b1;
              if ((burst_len != '0) && (BURST_W'(burst_cnt + 1'b1) == burst_len))
                burst_last <= 1'b1;
            end
`endif
          end
        end
        STEP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_enable_pulse_gen
// Directed + randomized bench for enable_pulse_gen. A behavioural model tracks
// the mode and the number of cycles since start, and predicts a pulse on every
// edge whose index is a multiple of the effective ratio.
// Build with +define+PRESCALER_BURST_EN to exercise the burst feature.
// -----------------------------------------------------------------------------
module tb_enable_pulse_gen;
  import enable_gen_pkg::*;

  localparam int DIV_W   = 8;
  localparam int BURST_W = 4;
  localparam int EXP_W   = 5;  // {done, state[1:0], running, enable}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             step = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             enable;
  logic             running;
  state_t           dbg_state;
`ifdef PRESCALER_BURST_EN
  logic [BURST_W-1:0] burst_len = '0;
  logic               done;
`endif

  enable_pulse_gen #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (4),
    .BURST_W     (BURST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .div_load  (div_load),
    .div_value (div_value),
`ifdef PRESCALER_BURST_EN
    .burst_len (burst_len),
    .done      (done),
`endif
    .enable    (enable),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];
  int pulse_seen = 0;
  int done_seen  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 step. j = edges since start, pulses = pulses this run.
  int m_mode   = 0;
  int m_div    = 4;
  int m_j      = 0;
  int m_pulses = 0;
  bit m_burst_end = 1'b0;

  task automatic model_step();
    logic e_en, e_done;
    int   eff;
    e_en   = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_div  = 4;
      m_burst_end = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (div_load) m_div = int'(div_value);
          if (start && !stop) begin
            m_mode = 1; m_j = 0; m_pulses = 0; m_burst_end = 1'b0;
          end else if (step && !start) begin
            m_mode = 2; e_en = 1'b1;
          end
        end
        1: begin
          if (m_burst_end) begin
            m_mode = 0; e_done = 1'b1; m_burst_end = 1'b0;
          end else if (stop) begin
            m_mode = 0;
          end else begin
            eff = (m_div < 2) ? 1 : m_div;
            m_j++;
            if (m_j % eff == 0) begin
              e_en = 1'b1;
              m_pulses++;
`ifdef PRESCALER_BURST_EN
              if (burst_len != 0 && m_pulses == int'(burst_len)) m_burst_end = 1'b1;
`endif
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
    exp_q.push_back({e_done, 2'(m_mode), (m_mode == 1), e_en});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [EXP_W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("enable",  16'(enable),     16'(e[0]));
    check("running", 16'(running),    16'(e[1]));
    check("state",   16'(dbg_state),  16'(e[3:2]));
`ifdef PRESCALER_BURST_EN
    check("done",    16'(done),       16'(e[4]));
    if (done) done_seen++;
`endif
    if (enable) pulse_seen++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1; cycle(); step = 1'b0;
  endtask

  task automatic do_load(input int v);
    div_load = 1'b1; div_value = DIV_W'(v); cycle(); div_load = 1'b0;
  endtask

  // Cycles from the start edge to the first enable, bounded at 20.
  task automatic first_latency(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      lat++;
      if (enable) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, snap, maxw, curw;

    // Reset held with start high: everything stays quiet.
    rst = 1'b1; start = 1'b1;
    cycles(2);
    check("rst_enable",  16'(enable),  16'd0);
    check("rst_running", 16'(running), 16'd0);
    rst = 1'b0; start = 1'b0;
    cycle();
    do_start();
    first_latency(lat);
    check("first_latency_default", 16'(lat), 16'd4);
    do_stop();

    // Ratio 3 for 20 cycles: six single-cycle pulses.
    do_load(3);
    do_start();
    snap = pulse_seen; maxw = 0; curw = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      curw = enable ? curw + 1 : 0;
      if (curw > maxw) maxw = curw;
    end
    check("div3_pulses", 16'(pulse_seen - snap), 16'd6);
    check("div3_width",  16'(maxw), 16'd1);
    do_stop();

    // Three separated single steps advance the downstream count by three.
    snap = pulse_seen;
    for (int i = 0; i < 3; i++) begin
      do_step();
      cycles($urandom_range(1, 4));
    end
    check("step_pulses", 16'(pulse_seen - snap), 16'd3);

    // Stop on the edge a pulse is due suppresses it; start&stop stays idle.
    do_load(4);
    do_start();
    cycles(3);
    do_stop();
    check("stop_suppress_en",  16'(enable),  16'd0);
    check("stop_running",      16'(running), 16'd0);
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 16'(dbg_state), 16'(IDLE));
    do_start();
    first_latency(lat);
    check("restart_latency", 16'(lat), 16'd4);
    do_stop();

    // Ratio 0 means every cycle; div_load during RUN is ignored.
    do_load(0);
    do_start();
    snap = pulse_seen;
    div_load = 1'b1; div_value = 8'd5;
    cycles(8);
    div_load = 1'b0;
    cycles(4);
    check("div0_continuous", 16'(pulse_seen - snap), 16'd12);
    do_stop();

    // rst mid-RUN returns to idle with the default ratio.
    do_start();
    cycles(3);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_mid_run", 16'(running), 16'd0);
    do_start();
    first_latency(lat);
    check("post_rst_latency", 16'(lat), 16'd4);
    do_stop();

`ifdef PRESCALER_BURST_EN
    // Burst of five at ratio 2, then an unbounded run.
    do_load(2);
    burst_len = 4'd5;
    snap = pulse_seen; done_seen = 0;
    do_start();
    cycles(16);
    check("burst_pulses", 16'(pulse_seen - snap), 16'd5);
    check("burst_done",   16'(done_seen), 16'd1);
    burst_len = 4'd0;
    snap = pulse_seen;
    do_start();
    cycles(20);
    check("burst0_pulses",  16'(pulse_seen - snap), 16'd10);
    check("burst0_running", 16'(running), 16'd1);
    do_stop();
`endif

    // Randomized control traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      step      = ($urandom_range(0, 7) == 0);
      div_load  = ($urandom_range(0, 5) == 0);
      div_value = DIV_W'($urandom_range(0, 6));
`ifdef PRESCALER_BURST_EN
      burst_len = BURST_W'($urandom_range(0, 4));
`endif
      cycle();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; div_load = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
